// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory load/store unit.
// Size codes follow the RV32 funct3 field of loads and stores.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement for stores, lane select and
// extension for loads, and misaligned/illegal access detection.
module lsu_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlane,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic [31:0] w_sh;

  assign w_byte = (i_size == SZ_B) || (i_size == SZ_BU);
  assign w_half = (i_size == SZ_H) || (i_size == SZ_HU);
  assign w_word = (i_size == SZ_W);
  assign w_sh   = i_rword >> {i_off, 3'b000};

  // Unsigned sizes are load-only, so a store with size[2] is illegal.
  assign o_misalign = !(w_byte || w_half || w_word)
                    || (i_we && i_size[2])
                    || (w_half && i_off[0])
                    || (w_word && (i_off != 2'b00));

  always_comb begin
    o_be    = '0;
    o_wlane = '0;
    unique case (1'b1)
      w_byte: begin
        o_be    = 4'b0001 << i_off;
        o_wlane = {4{i_wdata[7:0]}};
      end
      w_half: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wlane = {2{i_wdata[15:0]}};
      end
      w_word: begin
        o_be    = 4'b1111;
        o_wlane = i_wdata;
      end
      default: begin
        o_be    = '0;
        o_wlane = '0;
      end
    endcase
    if (o_misalign || !i_we) o_be = '0;
  end

  always_comb begin
    o_rdata = '0;
    unique case (1'b1)
      w_byte:
        o_rdata = {{24{!i_size[2] && w_sh[7]}}, w_sh[7:0]};
      w_half:
        o_rdata = {{16{!i_size[2] && w_sh[15]}}, w_sh[15:0]};
      w_word:
        o_rdata = i_rword;
      default:
        o_rdata = '0;
    endcase
    if (o_misalign || i_we) o_rdata = '0;
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data memory with sub-word access and a
// fixed response latency behind a valid/ready handshake.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2,
  parameter int TEST_ADDR  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  misalign,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] test_value
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                       (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam logic [2:0] CNT_INIT =
    (LAT > 1) ? 3'(LAT - 2) : 3'd0;
  localparam logic [AW-1:0] TEST_IDX = AW'(TEST_ADDR);

  state_t      r_state;
  logic [2:0]  r_cnt;
  req_t        r_req;
  logic        r_rsp_valid;
  logic        r_mis;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  req_t          w_in;
  req_t          w_cur;
  logic          w_accept;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_rdata;
  logic          w_mis;
  logic          w_unused;

  assign w_in = '{we: req_we, size: req_size,
                  addr: req_addr, wdata: req_wdata};

  assign req_ready = RESET && (r_state != ST_WAIT);
  assign w_accept  = req_valid && req_ready;
  assign stall     = w_accept || (r_state == ST_WAIT);

  // The commit edge ends cycle T+LAT-1; with LAT=1 it is the accept edge.
  assign w_cur    = (LAT == 1) ? w_in : r_req;
  assign w_commit = (LAT == 1) ? w_accept
                  : ((r_state == ST_WAIT) && (r_cnt == 3'd0));
  assign w_idx    = w_cur.addr[AW+1:2];
  assign w_unused = ^{w_cur.addr[31:AW+2]};

  lsu_align u_align (
    .i_we       (w_cur.we),
    .i_size     (w_cur.size),
    .i_off      (w_cur.addr[1:0]),
    .i_wdata    (w_cur.wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wlane    (w_wlane),
    .o_rdata    (w_rdata),
    .o_misalign (w_mis)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_mis       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= w_commit;
      r_mis       <= w_commit && w_mis;
      r_rdata     <= w_commit ? w_rdata : '0;
      if (w_accept) r_req <= w_in;
      if (r_state == ST_WAIT) begin
        if (r_cnt == 3'd0) r_state <= ST_RESP;
        else r_cnt <= r_cnt - 3'd1;
      end else if (w_accept) begin
        if (LAT == 1) begin
          r_state <= ST_RESP;
        end else begin
          r_state <= ST_WAIT;
          r_cnt   <= CNT_INIT;
        end
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign misalign   = r_mis;
  assign rsp_rdata  = r_rdata;
  assign test_value = r_mem[TEST_IDX];

endmodule
